// File: rtl/fake_netlist_bist_ctrl.sv
// BIST harness around a combinational fake netlist: LFSR stimulus on 11 inputs,
// MISR signature and ones count on the single response bit.
module fake_netlist_bist_ctrl #(
  parameter int unsigned PAT_W     = 11,
  parameter int unsigned SIG_W     = 16,
  parameter logic [10:0] LFSR_SEED = 11'h001,
  parameter int unsigned SETTLE    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_pat,
  output logic [PAT_W-1:0] pat_out,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      ones_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [PAT_W-1:0] Seed      = (LFSR_SEED == '0) ? PAT_W'(1) : PAT_W'(LFSR_SEED);
  localparam logic [SIG_W-1:0] Poly      = SIG_W'(16'h1021);
  localparam logic [1:0]       DrainInit = (SETTLE == 0) ? 2'd0 : 2'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] lfsr_q, lfsr_nxt;
  logic [15:0]      cnt_q;
  logic [1:0]       dcnt_q;
  logic [SIG_W-1:0] sig_q, sig_nxt;
  logic [15:0]      ones_q;
  logic             accept, run, last, sample_en, fb;

  assign accept   = (state_q == StIdle) && start;
  assign run      = (state_q == StRun);
  assign last     = (cnt_q == 16'd1);
  assign lfsr_nxt = {lfsr_q[PAT_W-2:0], lfsr_q[PAT_W-1] ^ lfsr_q[PAT_W-3]};
  assign fb       = sig_q[SIG_W-1] ^ resp_in;
  assign sig_nxt  = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? Poly : '0);

  // Valid tokens trail the patterns by SETTLE cycles; SETTLE=0 samples in the RUN cycle itself.
  if (SETTLE == 0) begin : g_no_delay
    assign sample_en = run;
  end else begin : g_delay
    logic [SETTLE-1:0] vld_q;
    always_ff @(posedge clk) begin
      if (!rst_n || accept) begin
        vld_q <= '0;
      end else begin
        vld_q <= (vld_q << 1) | SETTLE'(run);
      end
    end
    assign sample_en = vld_q[SETTLE-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_pat != 16'd0) ? StRun : StDone;
      StRun:   if (last) state_d = (SETTLE > 0) ? StDrain : StDone;
      StDrain: if (dcnt_q == 2'd0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= Seed;
      cnt_q  <= '0;
      dcnt_q <= '0;
      sig_q  <= '0;
      ones_q <= '0;
    end else begin
      if (accept) begin
        lfsr_q <= Seed;
        cnt_q  <= num_pat;
        sig_q  <= '0;
        ones_q <= '0;
      end
      if (run && !last) begin
        lfsr_q <= lfsr_nxt;
        cnt_q  <= cnt_q - 16'd1;
      end
      if (run && last) begin
        dcnt_q <= DrainInit;
      end
      if ((state_q == StDrain) && (dcnt_q != 2'd0)) begin
        dcnt_q <= dcnt_q - 2'd1;
      end
      if (sample_en) begin
        sig_q <= sig_nxt;
        if (resp_in && (ones_q != 16'hFFFF)) begin
          ones_q <= ones_q + 16'd1;
        end
      end
    end
  end

  assign pat_out   = lfsr_q;
  assign signature = sig_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_fake_netlist_bist_ctrl.sv
// Scoreboard bench for the BIST harness: one instance with SETTLE=0, one with SETTLE=2.
module tb_fake_netlist_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start0, start2;
  logic [15:0] num_pat;
  logic [10:0] pat0, pat2;
  logic        resp0, resp2, busy0, busy2, done0, done2;
  logic [15:0] sig0, sig2, ones0, ones2;
  int          mode0 = 0, mode2 = 0;
  int          n_checks = 0, n_errors = 0;
  bit          mon_en = 1'b1;
  logic [10:0] exp_pat_q[$];
  logic [31:0] exp_res_q[$];
  logic [31:0] mon_r;

  always #5 clk = ~clk;

  function automatic logic resp_of(input int m, input logic [10:0] p);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return ^p;
  endfunction

  function automatic logic [10:0] lfsr_next(input logic [10:0] q);
    return {q[9:0], q[10] ^ q[8]};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ ((s[15] ^ r) ? 16'h1021 : 16'h0000);
  endfunction

  always_comb resp0 = resp_of(mode0, pat0);
  always_comb resp2 = resp_of(mode2, pat2);

  fake_netlist_bist_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .num_pat(num_pat), .pat_out(pat0),
    .resp_in(resp0), .busy(busy0), .done(done0), .signature(sig0), .ones_cnt(ones0)
  );

  fake_netlist_bist_ctrl #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .num_pat(num_pat), .pat_out(pat2),
    .resp_in(resp2), .busy(busy2), .done(done2), .signature(sig2), .ones_cnt(ones2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer for the SETTLE=0 instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy0) begin
        if (exp_pat_q.size() == 0) check("pat_underflow", 32'd1, 32'd0);
        else check("pat_out", 32'(pat0), 32'(exp_pat_q.pop_front()));
      end
      if (done0) begin
        if (exp_res_q.size() == 0) begin
          check("res_underflow", 32'd1, 32'd0);
        end else begin
          mon_r = exp_res_q.pop_front();
          check("signature", 32'(sig0), 32'(mon_r[31:16]));
          check("ones_cnt", 32'(ones0), 32'(mon_r[15:0]));
        end
      end
    end
  end

  task automatic run0(input int n, input int m, input bit inject);
    logic [10:0] q = 11'h001;
    logic [15:0] s = '0, o = '0;
    int busy_cnt = 0, done_cnt = 0, done_cyc = -1, dups = 0;
    bit seen [2048];
    for (int i = 0; i < n; i++) begin
      exp_pat_q.push_back(q);
      s = misr(s, resp_of(m, q));
      if (resp_of(m, q)) o = o + 16'd1;
      if (i < n - 1) q = lfsr_next(q);
    end
    exp_res_q.push_back({s, o});
    mode0 = m;
    @(negedge clk);
    num_pat = 16'(n);
    start0  = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= n + 8; cyc++) begin
      start0 = 1'b0;
      if (busy0) begin
        busy_cnt++;
        if (seen[pat0] || pat0 == 11'h000) dups++;
        seen[pat0] = 1'b1;
      end
      if (done0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (inject && (cyc == 2 || done0)) start0 = 1'b1;
      @(negedge clk);
    end
    start0 = 1'b0;
    check("busy_cycles", busy_cnt, n);
    check("done_pulses", done_cnt, 1);
    check("done_cycle", done_cyc, n + 1);
    if (n == 2047) check("distinct", dups, 0);
    check("idle_sig", 32'(sig0), 32'(s));
    check("idle_ones", 32'(ones0), 32'(o));
    check("pending", exp_pat_q.size() + exp_res_q.size(), 0);
  endtask

  task automatic run2(input int n, input int m);
    logic [10:0] p[$];
    logic [10:0] q = 11'h001;
    logic [15:0] s = '0, o = '0;
    int busy_cnt = 0, done_cyc = -1, idx;
    for (int i = 0; i < n; i++) begin
      p.push_back(q);
      if (i < n - 1) q = lfsr_next(q);
    end
    // With a 2-cycle response latency, pattern k is sampled while pattern k+2 (or the last) shows.
    for (int k = 0; k < n; k++) begin
      idx = (k + 2 < n) ? k + 2 : n - 1;
      s = misr(s, resp_of(m, p[idx]));
      if (resp_of(m, p[idx])) o = o + 16'd1;
    end
    mode2 = m;
    @(negedge clk);
    num_pat = 16'(n);
    start2  = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int cyc = 1; cyc <= n + 10; cyc++) begin
      if (busy2) busy_cnt++;
      if (cyc == n + 1) check("hold_pat", 32'(pat2), 32'(p[n-1]));
      if (done2 && done_cyc < 0) begin
        done_cyc = cyc;
        check("sig_s2", 32'(sig2), 32'(s));
        check("ones_s2", 32'(ones2), 32'(o));
      end
      @(negedge clk);
    end
    check("busy_cycles_s2", busy_cnt, n + 2);
    check("done_cycle_s2", done_cyc, n + 3);
  endtask

  task automatic reset_mid_run();
    int done_cnt = 0, busy_cnt = 0;
    mon_en = 1'b0;
    mode0  = 2;
    @(negedge clk);
    num_pat = 16'd10;
    start0  = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_pat", 32'(pat0), 32'h001);
    check("rst_sig", 32'(sig0), 32'd0);
    check("rst_ones", 32'(ones0), 32'd0);
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (done0) done_cnt++;
      if (busy0) busy_cnt++;
      @(negedge clk);
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_no_busy", busy_cnt, 0);
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start0  = 1'b0;
    start2  = 1'b0;
    num_pat = '0;
    repeat (3) @(negedge clk);
    check("reset_pat", 32'(pat0), 32'h001);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_sig", 32'(sig0), 32'd0);
    check("reset_ones", 32'(ones0), 32'd0);
    check("reset_pat_s2", 32'(pat2), 32'h001);
    rst_n = 1'b1;

    run0(4, 2, 1'b0);
    run0(0, 2, 1'b0);
    run0(6, 2, 1'b1);
    run0(2047, 1, 1'b0);
    run0(2047, 1, 1'b0);
    run0(9, 2, 1'b0);
    run0(3, 0, 1'b0);
    run2(3, 0);
    run2(5, 2);
    run2(1, 2);
    reset_mid_run();
    run0(5, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
